// File: rtl/ft_pkg.sv
// Shared constants for the FT600 transmit path: header layout, channel IDs,
// scheduler state encoding and grant encoding.
package ft_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [3:0] CHAN_IQ   = 4'd0;
  localparam logic [3:0] CHAN_CT   = 4'd1;

  localparam int HDR_SYNC_LSB = 24;
  localparam int HDR_CHAN_LSB = 20;
  localparam int HDR_SEQ_LSB  = 16;
  localparam int HDR_LEN_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_LAST    = 2'd3
  } ft_state_t;

  typedef enum logic {
    GNT_IQ = 1'b0,
    GNT_CT = 1'b1
  } ft_grant_t;

endpackage

// File: rtl/ft_tx_sched.sv
// Packet scheduler: picks IQ or control-reply source, writes a header word and
// then the payload into the A2F FIFO, one packet at a time.
module ft_tx_sched
  import ft_pkg::*;
#(
  parameter int BURST_LEN = 256,
  parameter int CTRL_MAX  = 16,
  parameter int LVL_W     = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [31:0]      iq_rdata,
  input  logic             iq_empty,
  input  logic [LVL_W-1:0] iq_level,
  output logic             iq_rd_en,
  input  logic [31:0]      ct_rdata,
  input  logic             ct_empty,
  input  logic [LVL_W-1:0] ct_level,
  output logic             ct_rd_en,
  input  logic             a2f_afull,
  output logic             a2f_wr,
  output logic [31:0]      a2f_wdata,
  output logic             busy
);

  ft_state_t   state_reg, state_next;
  ft_grant_t   grant_reg, grant_next;
  ft_grant_t   last_grant_reg, last_grant_next;
  ft_grant_t   pick;
  logic [15:0] len_reg, len_next;
  logic [15:0] remaining_reg, remaining_next;
  logic [3:0]  seq_iq_reg, seq_iq_next;
  logic [3:0]  seq_ct_reg, seq_ct_next;
  logic        wr_pend_reg, wr_pend_next;

  logic        iq_ready, ct_ready, src_empty, rd_en, hdr_wr;
  logic [15:0] ct_len;
  logic [31:0] hdr_word;

  assign iq_ready  = enable && (32'(iq_level) >= 32'(BURST_LEN));
  assign ct_ready  = enable && !ct_empty;
  assign ct_len    = (32'(ct_level) > 32'(CTRL_MAX)) ? 16'(CTRL_MAX) : 16'(ct_level);
  assign src_empty = (grant_reg == GNT_CT) ? ct_empty : iq_empty;

  // Reads are gated by reset so an aborted packet never pulls another word.
  assign rd_en = (state_reg == ST_PAYLOAD) && !a2f_afull && !src_empty &&
                 (remaining_reg != 16'd0) && !reset;
  assign iq_rd_en = rd_en && (grant_reg == GNT_IQ);
  assign ct_rd_en = rd_en && (grant_reg == GNT_CT);
  assign busy     = (state_reg != ST_IDLE);

  always_comb begin
    hdr_word = '0;
    hdr_word[HDR_SYNC_LSB +: 8]  = SYNC_BYTE;
    hdr_word[HDR_CHAN_LSB +: 4]  = (grant_reg == GNT_CT) ? CHAN_CT : CHAN_IQ;
    hdr_word[HDR_SEQ_LSB  +: 4]  = (grant_reg == GNT_CT) ? seq_ct_reg : seq_iq_reg;
    hdr_word[HDR_LEN_LSB  +: 16] = len_reg;
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    len_next        = len_reg;
    remaining_next  = remaining_reg;
    seq_iq_next     = seq_iq_reg;
    seq_ct_next     = seq_ct_reg;
    wr_pend_next    = rd_en;
    hdr_wr          = 1'b0;
    pick            = GNT_IQ;
    case (state_reg)
      ST_IDLE: begin
        if (iq_ready || ct_ready) begin
          // On a tie the source that did not win last time goes next.
          if (iq_ready && ct_ready)
            pick = (last_grant_reg == GNT_IQ) ? GNT_CT : GNT_IQ;
          else
            pick = ct_ready ? GNT_CT : GNT_IQ;
          grant_next      = pick;
          last_grant_next = pick;
          len_next        = (pick == GNT_CT) ? ct_len : 16'(BURST_LEN);
          remaining_next  = (pick == GNT_CT) ? ct_len : 16'(BURST_LEN);
          state_next      = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!a2f_afull) begin
          hdr_wr = 1'b1;
          if (grant_reg == GNT_CT) seq_ct_next = seq_ct_reg + 4'd1;
          else                     seq_iq_next = seq_iq_reg + 4'd1;
          state_next = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (rd_en) begin
          remaining_next = remaining_reg - 16'd1;
          if (remaining_reg == 16'd1) state_next = ST_LAST;
        end else if (remaining_reg == 16'd0) begin
          state_next = ST_LAST;
        end
      end
      ST_LAST: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign a2f_wr    = !reset && (hdr_wr || wr_pend_reg);
  assign a2f_wdata = !a2f_wr ? 32'd0 :
                     hdr_wr  ? hdr_word :
                     (grant_reg == GNT_CT) ? ct_rdata : iq_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= GNT_IQ;
      last_grant_reg <= GNT_IQ;
      len_reg        <= 16'd0;
      remaining_reg  <= 16'd0;
      seq_iq_reg     <= 4'd0;
      seq_ct_reg     <= 4'd0;
      wr_pend_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      len_reg        <= len_next;
      remaining_reg  <= remaining_next;
      seq_iq_reg     <= seq_iq_next;
      seq_ct_reg     <= seq_ct_next;
      wr_pend_reg    <= wr_pend_next;
    end
  end

endmodule

// File: doc/ft_tx_sched.md
FT_TX_SCHED -- requirements
Module: ft_tx_sched

Interface
REQ-001 SHALL have parameter BURST_LEN, default 256: IQ payload words per packet, range 1..4095.
REQ-002 SHALL have parameter CTRL_MAX, default 16: maximum control payload words per packet, range 1..4095.
REQ-003 SHALL have parameter LVL_W, default 12: width of the source level inputs.
REQ-004 SHALL have port clk  input  1: single clock, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1: scheduling enable; sampled only in IDLE.
REQ-007 SHALL have ports iq_rdata  input  32 / iq_empty  input  1 / iq_level  input  LVL_W: IQ source FIFO.
REQ-008 SHALL have port iq_rd_en  output  1: IQ FIFO read strobe; data is valid one cycle later.
REQ-009 SHALL have ports ct_rdata  input  32 / ct_empty  input  1 / ct_level  input  LVL_W: control-reply source FIFO.
REQ-010 SHALL have port ct_rd_en  output  1: control FIFO read strobe; data is valid one cycle later.
REQ-011 SHALL have port a2f_afull  input  1: A2F FIFO almost-full, asserted with at least 2 free slots remaining.
REQ-012 SHALL have ports a2f_wr  output  1 / a2f_wdata  output  32: write port into the A2F FIFO that feeds the FT600 controller.
REQ-013 SHALL have port busy  output  1: high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, HDR, PAYLOAD, LAST.
REQ-015 SHALL, in IDLE with enable=1, treat IQ as ready iff iq_level >= BURST_LEN (equality qualifies) and CT as ready iff ct_empty=0.
REQ-016 SHALL arbitrate round-robin on a last-grant bit when both sources are ready; the last-grant bit resets to IQ, so CT wins the first tie.
REQ-017 SHALL latch grant and length on the IDLE->HDR transition: len = BURST_LEN for IQ, min(ct_level, CTRL_MAX) for CT.
REQ-018 SHALL stay in IDLE when enable=0 or no source is ready; enable deasserted mid-packet SHALL NOT truncate the packet.
REQ-019 SHALL, in HDR with a2f_afull=0, pulse a2f_wr once with header {8'hA5, chan[3:0], seq[3:0], len[15:0]}, chan 0=IQ, 1=CT, then enter PAYLOAD; with a2f_afull=1 it SHALL hold.
REQ-020 SHALL, in PAYLOAD, assert the granted rd_en in a cycle iff a2f_afull=0, the granted source's empty=0, and remaining>0, decrementing remaining on each strobe.
REQ-021 SHALL assert a2f_wr with a2f_wdata = granted rdata exactly one cycle after each rd_en, independent of a2f_afull in that cycle.
REQ-022 SHALL enter LAST after the strobe that brings remaining to 0, write the final word there, then return to IDLE, so header plus payload is exactly len+1 writes.
REQ-023 SHALL increment the granted channel's 4-bit seq after its header is written, wrapping 15->0; the other channel's seq SHALL be unchanged.
REQ-024 SHALL never assert iq_rd_en and ct_rd_en in the same cycle, and SHALL never interleave words of two packets.
REQ-025 SHALL drive a2f_wdata to 0 whenever a2f_wr=0.

Reset
REQ-026 SHALL, while reset=1, force on the next edge: state IDLE, last-grant IQ, both seq 0, remaining 0, and iq_rd_en, ct_rd_en, a2f_wr, busy all 0.
REQ-027 SHALL treat reset mid-packet as an abort: no further writes or reads, and no completion of the partial packet after release.

Structure
REQ-028 SHALL take the 8'hA5 sync byte, channel IDs, header field positions and state encoding from shared package ft_pkg.
REQ-029 SHALL be a single module with no sub-modules; the header word is formed inline.

Verification
REQ-030 SHALL cover: iq_level=256, ct_empty=1, afull=0 -> header 0xA5000100, then 256 data words in order; iq_rd_en count 256; busy low after LAST.
REQ-031 SHALL cover: both ready at the first decision with ct_level=40 -> CT packet first, header 0xA5100010, 16 words; then IQ packet seq 0; then CT seq 1.
REQ-032 SHALL cover: a2f_afull toggled 3 cycles on / 5 off during an IQ packet -> no a2f_wr more than 1 cycle after an afull-blocked rd_en, and no lost or duplicated words.
REQ-033 SHALL cover: 17 consecutive CT packets of 1 word -> seq field sequence 0..15, then 0.
REQ-034 SHALL cover: reset pulsed at payload word 100 of an IQ packet -> all strobes 0 on the next edge; with iq_level held at 300 after release, the next header has seq 0.
REQ-035 SHALL cover: enable dropped at payload word 10 -> packet completes all 256 words; no new header while enable=0.
